alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle 32-bit ALU: DATA_WIDTH-generic datapath, 4-bit opcode.
//  Adds XOR/NOR/SLTU/shifts and an optional iterative multiplier. Sits between operand issue and writeback in the multi-cycle CPU.
//  Every result, including single-cycle ops, is registered and returned over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must be a power of two, >= 8
//  SHAMT_W     $clog2(DATA_WIDTH)  shift-amount bits taken from B[SHAMT_W-1:0]
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           A/B/ALUop valid
//  in_ready   out  1           unit can accept an operation
//  A          in   DATA_WIDTH  operand A
//  B          in   DATA_WIDTH  operand B / shift amount
//  ALUop      in   4           opcode (see BEHAVIOUR)
//  out_valid  out  1           Result/flags valid
//  out_ready  in   1           consumer accepts result
//  Result     out  DATA_WIDTH  registered result
//  Overflow   out  1           signed overflow (ADD/SUB/SLT only, else 0)
//  CarryOut   out  1           ADD: carry out; SUB: borrow (=!cout); else 0
//  Zero       out  1           Result == 0
// BEHAVIOUR
//  Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT,
//   1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL; all other codes illegal -> Result 0, flags 0, 1-cycle latency.
//  Reset: state IDLE, in_ready 1, out_valid 0, Result 0, Overflow/CarryOut/Zero 0 (Zero held 0 while out_valid=0).
//  FSM IDLE -> (accept, non-MUL) -> DONE; IDLE -> (accept, MUL) -> MUL; MUL -> (counter hits DATA_WIDTH-1) -> DONE;
//   DONE -> (out_ready) -> IDLE. Accept = in_valid && in_ready; in_ready = (state==IDLE).
//  Latency: non-MUL out_valid the cycle after accept; MUL out_valid DATA_WIDTH+1 cycles after accept.
//  One adder serves ADD/SUB/SLT/SLTU: S = A + (B^inv) + inv, inv = SUB|SLT|SLTU.
//  SLT = S[msb]^Overflow; SLTU = !cout; result zero-extended to DATA_WIDTH.
//  Shifts use B[SHAMT_W-1:0] only; SRA replicates A[msb]. Shift amount 0 returns A unchanged.
//  MUL: unsigned shift-add, low DATA_WIDTH bits of product returned; Overflow/CarryOut 0.
//  DONE holds Result/flags stable while out_ready=0; no new accept until handshake completes (no bypass, max 1 in flight).
//  in_valid while busy: ignored, no latching; producer must hold.
//  rst_n asserted mid-MUL or in DONE: aborts immediately, result discarded, reset values apply.
//  Operands latched on accept; A/B/ALUop may change freely afterwards.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL opcode 1100 implemented as above, iterative sub-module instantiated.
//  ALU_MUL_EN undefined: 1100 is illegal (Result 0, flags 0, 1-cycle); MUL state and counter removed.
// STRUCTURE
//  Package alu_pkg: opcode localparams (ALU_AND..ALU_MUL), FSM state encoding (IDLE/MUL/DONE), 4-bit op width constant.
//  Sub-module alu_mul_iter (DATA_WIDTH): start/done, multiplicand/multiplier regs, accumulator, bit counter.
//  Compiled only under ALU_MUL_EN. All other ops in alu_mc combinational block feeding result regs.
// TESTING
//  1 ADD A=7FFFFFFF B=1 -> Result 80000000, Overflow 1, CarryOut 0, out_valid cycle after accept.
//  2 SUB A=0 B=1 -> Result FFFFFFFF, CarryOut 1; SLTU A=1 B=FFFFFFFF -> 1; SLT same operands -> 0.
//  3 SRA A=80000000 B=0000003F -> FFFFFFFF (shamt 31); SLL A=1 B=20 -> 1 (shamt 0).
//  4 MUL A=0000FFFF B=00010001 (ALU_MUL_EN) -> FFFFFFFF after 33 cycles, in_ready 0 throughout; undefined -> 0 after 1.
//  5 out_ready held 0 for 5 cycles in DONE -> Result stable, in_ready 0, new in_valid ignored until handshake.
//  6 rst_n pulsed low mid-MUL -> out_valid 0, in_ready 1 immediately; next op completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, operation width and controller state encoding for alu_mc.
package alu_pkg;
  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1010;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/alu_mc_if.sv
// Operand-issue / result-return handshake bundle between the CPU pipeline and alu_mc.
interface alu_mc_if #(parameter int DATA_WIDTH = 32);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     A;
  logic [DATA_WIDTH-1:0]     B;
  logic [alu_pkg::OP_W-1:0]  ALUop;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     Result;
  logic                      Overflow;
  logic                      CarryOut;
  logic                      Zero;

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Overflow, CarryOut, Zero
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock, low DATA_WIDTH product bits.
module alu_mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_product
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  // o_product is the accumulator after the step being taken this cycle, so it is final when o_done is high
  assign o_done    = r_busy && (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign o_product = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU with registered result; ALU_MUL_EN enables the iterative MUL opcode,
// otherwise MUL is treated as an illegal opcode.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_mc_if.slave bus
);
  localparam int MSB = DATA_WIDTH - 1;

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_ovf, r_cout;

  logic                  w_accept;
  logic                  w_inv;
  logic [DATA_WIDTH-1:0] w_bx;
  logic [DATA_WIDTH:0]   w_sum_ext;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_sum_c, w_add_ovf;
  logic [SHAMT_W-1:0]    w_shamt;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf, w_cout;

  assign w_accept = bus.in_valid && (r_state == IDLE);

  // Shared adder: subtract and both compares add the inverted B plus one
  assign w_inv     = (bus.ALUop == ALU_SUB) || (bus.ALUop == ALU_SLT) || (bus.ALUop == ALU_SLTU);
  assign w_bx      = bus.B ^ {DATA_WIDTH{w_inv}};
  assign w_sum_ext = {1'b0, bus.A} + {1'b0, w_bx} + {{DATA_WIDTH{1'b0}}, w_inv};
  assign w_sum     = w_sum_ext[MSB:0];
  assign w_sum_c   = w_sum_ext[DATA_WIDTH];
  assign w_add_ovf = (bus.A[MSB] == w_bx[MSB]) && (w_sum[MSB] != bus.A[MSB]);
  assign w_shamt   = bus.B[SHAMT_W-1:0];

  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_cout = 1'b0;
    case (bus.ALUop)
      ALU_AND:  w_res = bus.A & bus.B;
      ALU_OR:   w_res = bus.A | bus.B;
      ALU_XOR:  w_res = bus.A ^ bus.B;
      ALU_NOR:  w_res = ~(bus.A | bus.B);
      ALU_ADD: begin
        w_res  = w_sum;
        w_ovf  = w_add_ovf;
        w_cout = w_sum_c;
      end
      ALU_SUB: begin
        w_res  = w_sum;
        w_ovf  = w_add_ovf;
        w_cout = !w_sum_c;
      end
      ALU_SLT: begin
        w_res = {{(DATA_WIDTH-1){1'b0}}, w_sum[MSB] ^ w_add_ovf};
        w_ovf = w_add_ovf;
      end
      ALU_SLTU: w_res = {{(DATA_WIDTH-1){1'b0}}, !w_sum_c};
      ALU_SLL:  w_res = bus.A << w_shamt;
      ALU_SRL:  w_res = bus.A >> w_shamt;
      ALU_SRA:  w_res = $signed(bus.A) >>> w_shamt;
      default:  ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                  w_is_mul;
  logic                  w_mul_done;
  logic [DATA_WIDTH-1:0] w_mul_prod;

  assign w_is_mul = (bus.ALUop == ALU_MUL);

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mul),
    .i_a       (bus.A),
    .i_b       (bus.B),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef ALU_MUL_EN
      IDLE: if (w_accept) w_state_nxt = w_is_mul ? MUL : DONE;
      MUL:  if (w_mul_done) w_state_nxt = DONE;
`else
      IDLE: if (w_accept) w_state_nxt = DONE;
`endif
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_cout   <= w_cout;
      end
`ifdef ALU_MUL_EN
      if ((r_state == MUL) && w_mul_done) begin
        r_result <= w_mul_prod;
        r_ovf    <= 1'b0;
        r_cout   <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.Result    = r_result;
  assign bus.Overflow  = r_ovf;
  assign bus.CarryOut  = r_cout;
  assign bus.Zero      = (r_state == DONE) && (r_result == '0);
endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc (32-bit); honours ALU_MUL_EN for MUL expectations.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int DW = 32;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = DW + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct packed {
    logic [DW-1:0] res;
    logic          ovf;
    logic          cout;
    logic          zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  alu_mc_if #(.DATA_WIDTH(DW)) bus ();

  alu_mc #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    exp_t e;
    longint sa, sb_, sr;
    longint unsigned ua, ub, ur;
    int sh;
    e   = '0;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sh  = int'(b[4:0]);
    sr  = 0;
    ur  = 0;
    case (op)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0011: e.res = a ^ b;
      4'b0100: e.res = ~(a | b);
      4'b0010: begin
        ur = ua + ub;
        e.res = ur[31:0];
        e.cout = ur[32];
        sr = sa + sb_;
        e.ovf = (sr != longint'($signed(sr[31:0])));
      end
      4'b0110: begin
        e.res = a - b;
        e.cout = (a < b);
        sr = sa - sb_;
        e.ovf = (sr != longint'($signed(sr[31:0])));
      end
      4'b0111: begin
        e.res = {31'b0, (sa < sb_)};
        sr = sa - sb_;
        e.ovf = (sr != longint'($signed(sr[31:0])));
      end
      4'b0101: e.res = {31'b0, (a < b)};
      4'b1000: e.res = a << sh;
      4'b1001: e.res = a >> sh;
      4'b1010: begin
        sr = sa >>> sh;
        e.res = sr[31:0];
      end
`ifdef ALU_MUL_EN
      4'b1100: begin
        ur = ua * ub;
        e.res = ur[31:0];
      end
`endif
      default: e.res = '0;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(logic [3:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUop    = op;
    bus.A        = a;
    bus.B        = b;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", 32'(guard < 100), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.ALUop    = 4'($urandom);
    sb.push_back(model(op, a, b));
  endtask

  task automatic compare_front(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_result"}, bus.Result, e.res);
    check({tag, "_ovf"}, 32'(bus.Overflow), 32'(e.ovf));
    check({tag, "_cout"}, 32'(bus.CarryOut), 32'(e.cout));
    check({tag, "_zero"}, 32'(bus.Zero), 32'(e.zero));
  endtask

  task automatic recv(string tag, int exp_lat);
    int lat;
    bit busy_ok;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
    end while (!bus.out_valid && lat < 200);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_ready"}, 32'(busy_ok), 32'd1);
    check({tag, "_ready_in_done"}, 32'(bus.in_ready), 32'd0);
    compare_front(tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    exp_t hold;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALUop = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.Result, 32'd0);
    check("rst_flags", {29'b0, bus.Overflow, bus.CarryOut, bus.Zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);  recv("add_ovf", 1);
    send(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);  recv("add_carry", 1);
    send(ALU_SUB, 32'h0000_0000, 32'h0000_0001);  recv("sub_borrow", 1);
    send(ALU_SUB, 32'h8000_0000, 32'h0000_0001);  recv("sub_ovf", 1);
    send(ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF); recv("sltu", 1);
    send(ALU_SLT, 32'h0000_0001, 32'hFFFF_FFFF);  recv("slt", 1);
    send(ALU_SLT, 32'h8000_0000, 32'h0000_0001);  recv("slt_neg", 1);
    send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);  recv("and", 1);
    send(ALU_OR,  32'hF000_0000, 32'h0000_000F);  recv("or", 1);
    send(ALU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);  recv("xor_zero", 1);
    send(ALU_NOR, 32'h0F0F_0000, 32'h0000_F0F0);  recv("nor", 1);
    send(ALU_SRA, 32'h8000_0000, 32'h0000_003F);  recv("sra31", 1);
    send(ALU_SLL, 32'h0000_0001, 32'h0000_0020);  recv("sll0", 1);
    send(ALU_SLL, 32'h0000_0003, 32'h0000_0004);  recv("sll4", 1);
    send(ALU_SRL, 32'h8000_0000, 32'h0000_001F);  recv("srl31", 1);
    send(ALU_SRA, 32'h4000_0000, 32'h0000_0002);  recv("sra_pos", 1);
    send(4'b1011, 32'h1234_5678, 32'h0000_0001);  recv("illegal", 1);
    send(ALU_MUL, 32'h0000_FFFF, 32'h0001_0001);  recv("mul", MUL_LAT);
    send(ALU_MUL, 32'h0001_2345, 32'h0000_6789);  recv("mul2", MUL_LAT);

    // Backpressure: result must hold and a waiting producer must not be taken
    send(ALU_XOR, 32'h1357_9BDF, 32'h0F0F_0F0F);
    @(negedge clk);
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    hold = sb[0];
    bus.in_valid = 1'b1;
    bus.ALUop = ALU_ADD;
    bus.A = 32'h0000_0010;
    bus.B = 32'h0000_0020;
    sb.push_back(model(ALU_ADD, 32'h0000_0010, 32'h0000_0020));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_result", bus.Result, hold.res);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    compare_front("bp_first");
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    recv("bp_second", 1);

    // Reset while an operation is outstanding
    send(ALU_MUL, 32'h0000_1234, 32'h0000_5678);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_result", bus.Result, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(ALU_SUB, 32'h0000_0064, 32'h0000_0063);  recv("after_abort", 1);
    send(ALU_MUL, 32'h0000_0007, 32'h0000_0006);  recv("after_abort_mul", MUL_LAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
